// File: rtl/ras_ckpt.sv
// Return-address stack for a multi-wide fetch front end, with a
// per-cycle checkpoint that the branch unit restores on a flush.
module ras_ckpt #(
  parameter int RAS_ADDRESS  = 3,
  parameter int XLEN         = 32,
  parameter int RAS_LEN      = 1 << RAS_ADDRESS,
  parameter int FETCH_WIDTH  = 2,
  parameter bit WRAP_ON_FULL = 1'b1
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        push_valid,
  input  logic [XLEN-1:0]             push_addr,
  input  logic [FETCH_WIDTH-1:0]      pop_req,
  input  logic                        recover_valid,
  input  logic [RAS_ADDRESS-1:0]      recover_sp,
  input  logic [RAS_ADDRESS:0]        recover_cnt,
  input  logic [XLEN-1:0]             recover_top,
  output logic [FETCH_WIDTH*XLEN-1:0] ret_addr,
  output logic [FETCH_WIDTH-1:0]      ret_valid,
  output logic [RAS_ADDRESS-1:0]      snap_sp,
  output logic [RAS_ADDRESS:0]        snap_cnt,
  output logic [XLEN-1:0]             snap_top,
  output logic                        overflow
);

  localparam int AW = RAS_ADDRESS;
  localparam int CW = RAS_ADDRESS + 1;
  localparam logic [AW-1:0] A1 = AW'(1);
  localparam logic [CW-1:0] C1 = CW'(1);
  localparam logic [CW-1:0] CFULL = CW'(RAS_LEN);

  logic [XLEN-1:0] ras [RAS_LEN];

  logic [AW-1:0]          sp;
  logic [AW-1:0]          sp_n;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_n;
  logic [FETCH_WIDTH-1:0] grant;
  logic [AW-1:0]          rd_idx [FETCH_WIDTH];
  logic [CW-1:0]          k;
  logic [CW-1:0]          cnt_left;
  logic [AW-1:0]          wr_base;
  logic [AW-1:0]          top_idx;
  logic                   full;
  logic                   ovf_n;
  logic                   we;
  logic [AW-1:0]          wa;
  logic [XLEN-1:0]        wd;

  assign top_idx = sp - A1;

  // Each granted slot reads one entry deeper than the previous grant.
  always_comb begin
    k     = '0;
    grant = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      rd_idx[i] = sp - A1 - k[AW-1:0];
      if (pop_req[i] && (cnt > k)) begin
        grant[i] = 1'b1;
        k        = k + C1;
      end
    end
  end

  always_comb begin
    cnt_left = cnt - k;
    wr_base  = sp - k[AW-1:0];
    full     = (cnt_left == CFULL);
    sp_n     = wr_base;
    cnt_n    = cnt_left;
    ovf_n    = 1'b0;
    we       = 1'b0;
    wa       = wr_base;
    wd       = push_addr;
    if (recover_valid) begin
      // Rewrite the top entry in case wrong-path pushes clobbered it.
      sp_n  = recover_sp;
      cnt_n = recover_cnt;
      we    = (recover_cnt != '0);
      wa    = recover_sp - A1;
      wd    = recover_top;
    end else if (push_valid) begin
      ovf_n = full;
      if (!full || WRAP_ON_FULL) begin
        we    = 1'b1;
        sp_n  = wr_base + A1;
        cnt_n = full ? CFULL : cnt_left + C1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (we) begin
      ras[wa] <= wd;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sp        <= '0;
      cnt       <= '0;
      ret_addr  <= '0;
      ret_valid <= '0;
      snap_sp   <= '0;
      snap_cnt  <= '0;
      snap_top  <= '0;
      overflow  <= 1'b0;
    end else begin
      sp       <= sp_n;
      cnt      <= cnt_n;
      overflow <= ovf_n;
      snap_sp  <= sp;
      snap_cnt <= cnt;
      snap_top <= ras[top_idx];
      if (recover_valid) begin
        ret_valid <= '0;
      end else begin
        ret_valid <= grant;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          if (grant[i]) begin
            ret_addr[i*XLEN +: XLEN] <= ras[rd_idx[i]];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt: one instance in wrap mode, one in
// drop mode, both fed the same stimulus.
module tb_ras_ckpt;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        push_valid;
  logic [31:0] push_addr;
  logic [1:0]  pop_req;
  logic        recover_valid;
  logic [2:0]  recover_sp;
  logic [3:0]  recover_cnt;
  logic [31:0] recover_top;

  logic [63:0] w_ret_addr, d_ret_addr;
  logic [1:0]  w_ret_valid, d_ret_valid;
  logic [2:0]  w_snap_sp, d_snap_sp;
  logic [3:0]  w_snap_cnt, d_snap_cnt;
  logic [31:0] w_snap_top, d_snap_top;
  logic        w_overflow, d_overflow;

  int vectors = 0;
  int miscompares = 0;

  ras_ckpt #(.RAS_ADDRESS(3), .XLEN(32), .FETCH_WIDTH(2),
             .WRAP_ON_FULL(1'b1)) dut_w (
    .CLK(CLK), .reset(reset),
    .push_valid(push_valid), .push_addr(push_addr),
    .pop_req(pop_req), .recover_valid(recover_valid),
    .recover_sp(recover_sp), .recover_cnt(recover_cnt),
    .recover_top(recover_top),
    .ret_addr(w_ret_addr), .ret_valid(w_ret_valid),
    .snap_sp(w_snap_sp), .snap_cnt(w_snap_cnt),
    .snap_top(w_snap_top), .overflow(w_overflow)
  );

  ras_ckpt #(.RAS_ADDRESS(3), .XLEN(32), .FETCH_WIDTH(2),
             .WRAP_ON_FULL(1'b0)) dut_d (
    .CLK(CLK), .reset(reset),
    .push_valid(push_valid), .push_addr(push_addr),
    .pop_req(pop_req), .recover_valid(recover_valid),
    .recover_sp(recover_sp), .recover_cnt(recover_cnt),
    .recover_top(recover_top),
    .ret_addr(d_ret_addr), .ret_valid(d_ret_valid),
    .snap_sp(d_snap_sp), .snap_cnt(d_snap_cnt),
    .snap_top(d_snap_top), .overflow(d_overflow)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!reset && recover_valid) begin
      assert (recover_cnt <= 4'd8)
        else $error("illegal recover_cnt %0d", recover_cnt);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    push_valid    = 1'b0;
    push_addr     = '0;
    pop_req       = '0;
    recover_valid = 1'b0;
    recover_sp    = '0;
    recover_cnt   = '0;
    recover_top   = '0;
  endtask

  task automatic step(input logic pv, input logic [31:0] pa,
                      input logic [1:0] pr);
    push_valid = pv;
    push_addr  = pa;
    pop_req    = pr;
    tick();
    idle_inputs();
  endtask

  task automatic recover(input logic [2:0] rsp, input logic [3:0] rcnt,
                         input logic [31:0] rtop);
    recover_valid = 1'b1;
    recover_sp    = rsp;
    recover_cnt   = rcnt;
    recover_top   = rtop;
    push_valid    = 1'b1;
    push_addr     = 32'hDEAD;
    pop_req       = 2'b11;
    tick();
    idle_inputs();
  endtask

  // Called just after a clock edge; pulses reset with no edge inside.
  task automatic do_reset;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    #1 reset = 1'b1;
    #1;
    vectors++; if (w_ret_valid !== 2'b00) begin miscompares++; $display("FAIL rst_valid got %b want 00", w_ret_valid); end
    vectors++; if (w_ret_addr !== 64'h0) begin miscompares++; $display("FAIL rst_addr got %h want 0", w_ret_addr); end
    vectors++; if (w_snap_sp !== 3'd0 || w_snap_cnt !== 4'd0) begin miscompares++; $display("FAIL rst_snap got sp=%0d cnt=%0d want 0/0", w_snap_sp, w_snap_cnt); end
    vectors++; if (w_snap_top !== 32'h0) begin miscompares++; $display("FAIL rst_top got %h want 0", w_snap_top); end
    vectors++; if (w_overflow !== 1'b0 || d_overflow !== 1'b0) begin miscompares++; $display("FAIL rst_ovf got %b/%b want 0/0", w_overflow, d_overflow); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_push_pop;
    step(1'b1, 32'h100, 2'b00);
    step(1'b1, 32'h200, 2'b00);
    step(1'b1, 32'h300, 2'b00);
    vectors++; if (w_snap_sp !== 3'd2 || w_snap_cnt !== 4'd2 || w_snap_top !== 32'h200) begin miscompares++; $display("FAIL t1_snap got sp=%0d cnt=%0d top=%h want 2/2/200", w_snap_sp, w_snap_cnt, w_snap_top); end
    step(1'b0, 32'h0, 2'b11);
    vectors++; if (w_ret_valid !== 2'b11) begin miscompares++; $display("FAIL t1_valid got %b want 11", w_ret_valid); end
    vectors++; if (w_ret_addr[31:0] !== 32'h300) begin miscompares++; $display("FAIL t1_slot0 got %h want 300", w_ret_addr[31:0]); end
    vectors++; if (w_ret_addr[63:32] !== 32'h200) begin miscompares++; $display("FAIL t1_slot1 got %h want 200", w_ret_addr[63:32]); end
    vectors++; if (w_snap_cnt !== 4'd3 || w_snap_top !== 32'h300) begin miscompares++; $display("FAIL t1_snap3 got cnt=%0d top=%h want 3/300", w_snap_cnt, w_snap_top); end
    step(1'b0, 32'h0, 2'b00);
    vectors++; if (w_snap_sp !== 3'd1 || w_snap_cnt !== 4'd1) begin miscompares++; $display("FAIL t1_after got sp=%0d cnt=%0d want 1/1", w_snap_sp, w_snap_cnt); end
    vectors++; if (w_ret_valid !== 2'b00 || w_ret_addr !== 64'h0000_0200_0000_0300) begin miscompares++; $display("FAIL t1_hold got v=%b a=%h want 00/200_300", w_ret_valid, w_ret_addr); end
  endtask

  task automatic test_underflow;
    do_reset();
    step(1'b0, 32'h0, 2'b11);
    vectors++; if (w_ret_valid !== 2'b00) begin miscompares++; $display("FAIL t2_empty got %b want 00", w_ret_valid); end
    step(1'b0, 32'h0, 2'b00);
    vectors++; if (w_snap_cnt !== 4'd0) begin miscompares++; $display("FAIL t2_cnt0 got %0d want 0", w_snap_cnt); end
    step(1'b1, 32'hA0, 2'b00);
    step(1'b0, 32'h0, 2'b11);
    vectors++; if (w_ret_valid !== 2'b01) begin miscompares++; $display("FAIL t2_one got %b want 01", w_ret_valid); end
    vectors++; if (w_ret_addr !== 64'h0000_0000_0000_00A0) begin miscompares++; $display("FAIL t2_addr got %h want 0_A0", w_ret_addr); end
    step(1'b0, 32'h0, 2'b00);
    vectors++; if (w_snap_cnt !== 4'd0) begin miscompares++; $display("FAIL t2_cnt1 got %0d want 0", w_snap_cnt); end
  endtask

  task automatic test_overflow;
    logic [31:0] ew, ed;
    do_reset();
    for (int j = 1; j <= 9; j++) begin
      step(1'b1, 32'(j * 16), 2'b00);
      vectors++;
      if (w_overflow !== (j == 9) || d_overflow !== (j == 9)) begin
        miscompares++;
        $display("FAIL t3_ovf push%0d got %b/%b want %b", j, w_overflow, d_overflow, (j == 9));
      end
    end
    for (int p = 0; p < 8; p++) begin
      ew = 32'h90 - 32'(p * 16);
      ed = 32'h80 - 32'(p * 16);
      step(1'b0, 32'h0, 2'b01);
      vectors++;
      if (w_ret_valid !== 2'b01 || w_ret_addr[31:0] !== ew) begin
        miscompares++;
        $display("FAIL t3_wrap pop%0d got %b/%h want 01/%h", p, w_ret_valid, w_ret_addr[31:0], ew);
      end
      vectors++;
      if (d_ret_valid !== 2'b01 || d_ret_addr[31:0] !== ed) begin
        miscompares++;
        $display("FAIL t3_drop pop%0d got %b/%h want 01/%h", p, d_ret_valid, d_ret_addr[31:0], ed);
      end
    end
    vectors++; if (w_overflow !== 1'b0 || d_overflow !== 1'b0) begin miscompares++; $display("FAIL t3_ovf_clr got %b/%b want 0/0", w_overflow, d_overflow); end
    step(1'b0, 32'h0, 2'b01);
    vectors++; if (w_ret_valid !== 2'b00 || d_ret_valid !== 2'b00) begin miscompares++; $display("FAIL t3_pop9 got %b/%b want 00/00", w_ret_valid, d_ret_valid); end
  endtask

  task automatic test_push_pop_same;
    do_reset();
    step(1'b1, 32'h100, 2'b00);
    step(1'b1, 32'h200, 2'b00);
    step(1'b1, 32'h500, 2'b01);
    vectors++; if (w_ret_valid !== 2'b01 || w_ret_addr[31:0] !== 32'h200) begin miscompares++; $display("FAIL t4_pop got %b/%h want 01/200", w_ret_valid, w_ret_addr[31:0]); end
    step(1'b0, 32'h0, 2'b00);
    vectors++; if (w_snap_sp !== 3'd2 || w_snap_cnt !== 4'd2 || w_snap_top !== 32'h500) begin miscompares++; $display("FAIL t4_snap got sp=%0d cnt=%0d top=%h want 2/2/500", w_snap_sp, w_snap_cnt, w_snap_top); end
    step(1'b0, 32'h0, 2'b11);
    vectors++; if (w_ret_addr !== 64'h0000_0100_0000_0500) begin miscompares++; $display("FAIL t4_stack got %h want 100_500", w_ret_addr); end
  endtask

  task automatic test_recover;
    do_reset();
    step(1'b1, 32'h100, 2'b00);
    step(1'b1, 32'h200, 2'b00);
    step(1'b0, 32'h0, 2'b00);
    vectors++; if (w_snap_sp !== 3'd2 || w_snap_cnt !== 4'd2 || w_snap_top !== 32'h200) begin miscompares++; $display("FAIL t5_cap got sp=%0d cnt=%0d top=%h want 2/2/200", w_snap_sp, w_snap_cnt, w_snap_top); end
    step(1'b0, 32'h0, 2'b01);
    step(1'b1, 32'hBAD, 2'b00);
    step(1'b1, 32'hBEE, 2'b00);
    recover(3'd2, 4'd2, 32'h200);
    vectors++; if (w_ret_valid !== 2'b00 || d_ret_valid !== 2'b00) begin miscompares++; $display("FAIL t5_rv got %b/%b want 00/00", w_ret_valid, d_ret_valid); end
    vectors++; if (w_snap_sp !== 3'd3 || w_snap_cnt !== 4'd3 || w_snap_top !== 32'hBEE) begin miscompares++; $display("FAIL t5_snap got sp=%0d cnt=%0d top=%h want 3/3/BEE", w_snap_sp, w_snap_cnt, w_snap_top); end
    step(1'b0, 32'h0, 2'b01);
    vectors++; if (w_ret_valid !== 2'b01 || w_ret_addr[31:0] !== 32'h200) begin miscompares++; $display("FAIL t5_pop1 got %b/%h want 01/200", w_ret_valid, w_ret_addr[31:0]); end
    step(1'b0, 32'h0, 2'b01);
    vectors++; if (d_ret_valid !== 2'b01 || d_ret_addr[31:0] !== 32'h100) begin miscompares++; $display("FAIL t5_pop2 got %b/%h want 01/100", d_ret_valid, d_ret_addr[31:0]); end
  endtask

  task automatic test_back_to_back;
    recover(3'd1, 4'd1, 32'h111);
    recover(3'd2, 4'd2, 32'h222);
    vectors++; if (w_snap_sp !== 3'd1 || w_snap_cnt !== 4'd1 || w_snap_top !== 32'h111) begin miscompares++; $display("FAIL t7_snap got sp=%0d cnt=%0d top=%h want 1/1/111", w_snap_sp, w_snap_cnt, w_snap_top); end
    step(1'b0, 32'h0, 2'b11);
    vectors++; if (w_ret_valid !== 2'b11 || w_ret_addr !== 64'h0000_0111_0000_0222) begin miscompares++; $display("FAIL t7_pop got %b/%h want 11/111_222", w_ret_valid, w_ret_addr); end
  endtask

  task automatic test_async_reset;
    do_reset();
    for (int j = 1; j <= 6; j++) step(1'b1, 32'(j), 2'b00);
    step(1'b0, 32'h0, 2'b01);
    vectors++; if (w_ret_valid !== 2'b01 || w_snap_cnt !== 4'd6) begin miscompares++; $display("FAIL t6_pre got %b/%0d want 01/6", w_ret_valid, w_snap_cnt); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (w_ret_valid !== 2'b00 || w_ret_addr !== 64'h0) begin miscompares++; $display("FAIL t6_rv got %b/%h want 00/0", w_ret_valid, w_ret_addr); end
    vectors++; if (w_snap_sp !== 3'd0 || w_snap_cnt !== 4'd0 || w_snap_top !== 32'h0) begin miscompares++; $display("FAIL t6_snap got sp=%0d cnt=%0d top=%h want 0/0/0", w_snap_sp, w_snap_cnt, w_snap_top); end
    reset = 1'b0;
    step(1'b0, 32'h0, 2'b01);
    vectors++; if (w_ret_valid !== 2'b00 || w_snap_cnt !== 4'd0) begin miscompares++; $display("FAIL t6_post got %b/%0d want 00/0", w_ret_valid, w_snap_cnt); end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_underflow();
    test_overflow();
    test_push_pop_same();
    test_recover();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ras_ckpt.md
Name: ras_ckpt

Overview:
Parametrised return-address stack with checkpointed recovery for the multi-wide fetch front end.
- Accepts up to FETCH_WIDTH return pops and one call push per cycle.
- Tracks occupancy, with a selectable overflow policy.
- Emits a registered per-cycle checkpoint (pointer, count, top entry). The branch unit restores that checkpoint on a misprediction flush.

Parameters:
RAS_ADDRESS, 3, log2 of stack depth
XLEN, 32, return-address width
RAS_LEN, 1<<RAS_ADDRESS, number of entries
FETCH_WIDTH, 2, pop slots per cycle (1..4)
WRAP_ON_FULL, 1, 1 = push when full overwrites the oldest entry (circular); 0 = push when full is dropped

Ports:
CLK  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
push_valid  in  1  call in current fetch bundle
push_addr  in  XLEN  return address to push
pop_req  in  FETCH_WIDTH  bit i = slot i is a predicted return
recover_valid  in  1  restore checkpoint
recover_sp  in  RAS_ADDRESS  checkpointed write pointer
recover_cnt  in  RAS_ADDRESS+1  checkpointed occupancy
recover_top  in  XLEN  checkpointed top-of-stack value
ret_addr  out  FETCH_WIDTH*XLEN  slot i at [i*XLEN +: XLEN]
ret_valid  out  FETCH_WIDTH  slot i prediction valid
snap_sp  out  RAS_ADDRESS  checkpoint: pointer before this cycle's update
snap_cnt  out  RAS_ADDRESS+1  checkpoint: occupancy before this cycle's update
snap_top  out  XLEN  checkpoint: RAS[sp-1] before this cycle's update
overflow  out  1  one-cycle pulse: push dropped (WRAP_ON_FULL=0) or oldest entry overwritten (WRAP_ON_FULL=1)

Behaviour:
- State:
  - sp: next write index, arithmetic mod RAS_LEN.
  - cnt: occupancy, 0..RAS_LEN.
  - Storage array in distributed RAM.
- Reset (async): sp=0, cnt=0, ret_addr=0, ret_valid=0, snap_*=0, overflow=0. Storage is not reset.
- All outputs are registered and appear one cycle after the inputs.
- Normal cycle (recover_valid=0), evaluated in this order:
  - Pops, in slot order 0..FETCH_WIDTH-1. Let k = number of granted pops in lower slots.
    - Slot i is granted if pop_req[i] and cnt > k.
    - A granted slot reads RAS[sp-1-k], sets ret_valid[i]=1, and k increments.
    - An ungranted slot (no request, or underflow) gives ret_valid[i]=0 and leaves ret_addr slot i holding its previous value.
  - Push, applied after pops: write index w = sp-k.
    - If cnt-k < RAS_LEN, or WRAP_ON_FULL=1: RAS[w]<=push_addr, sp<=w+1, cnt<=min(cnt-k+1, RAS_LEN).
    - overflow=1 when cnt-k == RAS_LEN, in either mode.
    - If WRAP_ON_FULL=0 and full: push is dropped, sp<=w, cnt<=cnt-k, overflow=1.
  - No push: sp<=sp-k, cnt<=cnt-k.
  - Push and pop in the same cycle: popped values come from the pre-push contents.
- Checkpoint: every non-reset cycle, snap_sp<=sp, snap_cnt<=cnt, snap_top<=RAS[sp-1], all pre-update values. This includes recovery cycles.
- Recovery (recover_valid=1) has priority over all push/pop in the same cycle; those requests are discarded.
  - sp<=recover_sp, cnt<=recover_cnt.
  - If recover_cnt!=0: RAS[recover_sp-1]<=recover_top, repairing a top entry clobbered by wrong-path pushes.
  - ret_valid<=0, overflow<=0.
- Back-to-back recoveries: the last one wins. The cycle after a recovery operates on the restored state.
- Reset asserted mid-operation clears state immediately, regardless of CLK.
- cnt may never exceed RAS_LEN. Recovery with recover_cnt>RAS_LEN is illegal; the bench asserts it never occurs.

Test Plan (RAS_ADDRESS=3, FETCH_WIDTH=2, XLEN=32):
1. Reset, push 0x100, 0x200, 0x300 over three cycles, then pop_req=2'b11 -> next cycle ret_addr slot0=0x300, slot1=0x200, ret_valid=2'b11; cnt=1, sp=1.
2. Empty stack, pop_req=2'b11 -> ret_valid=2'b00, cnt stays 0. With one entry 0xA0 -> ret_valid=2'b01, slot0=0xA0.
3. WRAP_ON_FULL=1: 9 pushes 0x10..0x90, then 8 single pops -> 0x90 down to 0x20; overflow pulses on the 9th push; 9th pop gives ret_valid=0. Rerun with WRAP_ON_FULL=0: 9th push dropped, overflow=1, first pop returns 0x80.
4. Stack [0x100,0x200], pop_req=2'b01 with push_valid=1, push_addr=0x500 in the same cycle -> ret_addr slot0=0x200; stack becomes [0x100,0x500], cnt=2.
5. Capture snap (sp=2, cnt=2, top=0x200). Then pop, push 0xBAD, push 0xBEE. Then recover with the captured values, asserting push_valid and pop_req in the same cycle -> push/pop ignored, ret_valid=0; next pop returns 0x200, then 0x100.
6. Assert reset asynchronously between clock edges while cnt=5 -> ret_valid and snap_* read 0 before the next edge; the following pop gives ret_valid=0.
